// File: rtl/llm_outlier_detector.sv
// -----------------------------------------------------------------------------
// llm_outlier_detector
//
// Streaming outlier flagger for the int8 mixed-precision activation datapath.
// Each beat carries PARALLELISM signed elements. Every element with |x| >= THRES
// is flagged, the flags of a beat are counted, and beats are grouped into rows
// of ROW_BEATS so that a row-level outlier flag is produced on the last beat of
// each row. Data passes through unchanged behind a single-stage pipeline
// register (1-cycle latency, full throughput).
//
// Optional feature: define OUTLIER_STATS_EN to add the total_outliers port, a
// saturating STAT_WIDTH-bit running sum of outlier_count over output transfers.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-low reset
//   data_in        in   PARALLELISM x DATA_WIDTH signed elements
//   data_in_valid  in   input beat valid
//   data_in_ready  out  block can accept a beat
//   data_out       out  registered copy of data_in
//   outlier_mask   out  bit i set = element i is an outlier
//   outlier_count  out  popcount of outlier_mask
//   row_outlier    out  OR of all masks in the row, on the last beat only
//   data_out_last  out  beat is the last of its row
//   data_out_valid out  output beat valid
//   data_out_ready in   downstream accepts the beat
//   total_outliers out  saturating outlier total (OUTLIER_STATS_EN only)
// -----------------------------------------------------------------------------
module llm_outlier_detector #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned THRES       = 128,
  parameter int unsigned ROW_BEATS   = 8,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]  data_in,
  input  logic                                    data_in_valid,
  output logic                                    data_in_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]  data_out,
  output logic [PARALLELISM-1:0]                  outlier_mask,
  output logic [$clog2(PARALLELISM+1)-1:0]        outlier_count,
  output logic                                    row_outlier,
  output logic                                    data_out_last,
  output logic                                    data_out_valid,
  input  logic                                    data_out_ready
`ifdef OUTLIER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]                   total_outliers
`endif
);

  localparam int unsigned CNT_W = $clog2(PARALLELISM + 1);
  localparam int unsigned BC_W  = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

  // Threshold held in DATA_WIDTH+1 bits so that both +THRES and -THRES are
  // representable even when THRES = 2^(DATA_WIDTH-1).
  localparam logic signed [DATA_WIDTH:0] THR_POS = (DATA_WIDTH + 1)'(THRES);
  localparam logic signed [DATA_WIDTH:0] THR_NEG = -THR_POS;

  if (ROW_BEATS < 1 || THRES < 1 || THRES > 2 ** (DATA_WIDTH - 1) || STAT_WIDTH < 1)
  begin : g_bad_param
    $error("llm_outlier_detector: illegal parameter value");
  end

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_e;

  state_e state_q, state_d;

  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data_q;
  logic [PARALLELISM-1:0]                 mask_q, mask_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   last_q;
  logic                                   row_q, row_d;
  logic [BC_W-1:0]                        beat_cnt_q;
  logic                                   row_acc_q;
  logic signed [DATA_WIDTH:0]             x_ext;
  logic                                   is_last;
  logic                                   in_xfer;
  logic                                   out_xfer;

  // ---------------------------------------------------------------------------
  // Per-element classification and popcount
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before any conditional or
  // loop assignment, so no path leaves a value unassigned and no latch forms.
  always_comb begin
    mask_d = '0;
    cnt_d  = '0;
    x_ext  = '0;
    for (int i = 0; i < int'(PARALLELISM); i++) begin
      // Sign-extend by one bit; the most negative input then compares below
      // THR_NEG instead of wrapping on negation.
      x_ext     = {data_in[i][DATA_WIDTH-1], data_in[i]};
      mask_d[i] = (x_ext >= THR_POS) || (x_ext <= THR_NEG);
      cnt_d     = cnt_d + CNT_W'(mask_d[i]);
    end
  end

  // Row bookkeeping: row_acc_q holds the OR of the earlier beats of this row.
  assign is_last = (beat_cnt_q == BC_W'(ROW_BEATS - 1));
  assign row_d   = is_last ? (row_acc_q | (|mask_d)) : 1'b0;

  assign in_xfer  = data_in_valid && data_in_ready;
  assign out_xfer = data_out_valid && data_out_ready;

  // ---------------------------------------------------------------------------
  // Pipeline-register FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    data_out_valid = (state_q == S_FULL);
    data_in_ready  = (state_q == S_EMPTY) || data_out_ready;
    unique case (state_q)
      S_EMPTY: if (in_xfer) state_d = S_FULL;
      S_FULL:  if (out_xfer && !in_xfer) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and row tracking, all loaded together on an input transfer
  // ---------------------------------------------------------------------------
  // NOTE: the data register is reset as well as the control state, because
  // the outputs must read as zero during reset, not merely be flagged invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      row_q      <= 1'b0;
      beat_cnt_q <= '0;
      row_acc_q  <= 1'b0;
    end else if (in_xfer) begin
      data_q     <= data_in;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      last_q     <= is_last;
      row_q      <= row_d;
      beat_cnt_q <= is_last ? '0 : beat_cnt_q + BC_W'(1);
      row_acc_q  <= is_last ? 1'b0 : (row_acc_q | (|mask_d));
    end
  end

  assign data_out      = data_q;
  assign outlier_mask  = mask_q;
  assign outlier_count = cnt_q;
  assign data_out_last = last_q;
  assign row_outlier   = row_q;

`ifdef OUTLIER_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating running total of flagged elements leaving the block
  // ---------------------------------------------------------------------------
  logic [STAT_WIDTH-1:0] total_q;
  logic [STAT_WIDTH:0]   total_sum;

  // One guard bit catches the carry; on overflow the counter pins at all-ones.
  assign total_sum = {1'b0, total_q} + (STAT_WIDTH + 1)'(cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= '0;
    end else if (out_xfer) begin
      total_q <= total_sum[STAT_WIDTH] ? '1 : total_sum[STAT_WIDTH-1:0];
    end
  end

  assign total_outliers = total_q;
`endif

endmodule

// File: tb/tb_llm_outlier_detector.sv
// -----------------------------------------------------------------------------
// tb_llm_outlier_detector
//
// Self-checking bench for llm_outlier_detector (DATA_WIDTH=16, PARALLELISM=4,
// THRES=128, ROW_BEATS=3, STAT_WIDTH=4). A behavioural model tracks the one
// beat the block may hold and the row position; a negedge compare process
// checks every output against it each cycle. Directed phases add hand-computed
// literal expectations, then a randomized phase exercises valid/ready mixes.
// -----------------------------------------------------------------------------
module tb_llm_outlier_detector;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int TH = 128;
  localparam int RB = 3;
  localparam int SW = 4;
  localparam int CW = $clog2(P + 1);

  typedef logic [P-1:0][DW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  beat_t         data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  beat_t         data_out;
  logic [P-1:0]  outlier_mask;
  logic [CW-1:0] outlier_count;
  logic          row_outlier;
  logic          data_out_last;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
`ifdef OUTLIER_STATS_EN
  logic [SW-1:0] total_outliers;
`endif

  int total = 0;
  int bad   = 0;

  llm_outlier_detector #(
    .DATA_WIDTH (DW),
    .PARALLELISM(P),
    .THRES      (TH),
    .ROW_BEATS  (RB),
    .STAT_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .outlier_mask  (outlier_mask),
    .outlier_count (outlier_count),
    .row_outlier   (row_outlier),
    .data_out_last (data_out_last),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
`ifdef OUTLIER_STATS_EN
    ,
    .total_outliers(total_outliers)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the beat currently presented, plus row position state
  // ---------------------------------------------------------------------------
  bit           m_valid = 0;
  beat_t        m_data  = '0;
  logic [P-1:0] m_mask  = '0;
  int           m_cnt   = 0;
  bit           m_last  = 0;
  bit           m_row   = 0;
  int           m_pos   = 0;
  bit           m_any   = 0;
  int           m_total = 0;

  always @(negedge clk) begin : compare
    bit           in_x, out_x, exp_rdy;
    logic [P-1:0] mk;
    int           c, v;
    if (!rst) begin
      m_valid = 0; m_data = '0; m_mask = '0; m_cnt = 0;
      m_last  = 0; m_row = 0; m_pos = 0; m_any = 0; m_total = 0;
      check("rst_valid", data_out_valid, 0);
      check("rst_in_ready", data_in_ready, 1);
    end else begin
      exp_rdy = !m_valid || data_out_ready;
      check("valid", data_out_valid, m_valid);
      check("in_ready", data_in_ready, exp_rdy);
      if (m_valid) begin
        check("data", data_out, m_data);
        check("mask", outlier_mask, m_mask);
        check("count", outlier_count, m_cnt);
        check("last", data_out_last, m_last);
        check("row", row_outlier, m_row);
      end
`ifdef OUTLIER_STATS_EN
      check("stats", total_outliers, m_total);
`endif
      // Predict what the coming clock edge does.
      in_x  = data_in_valid && exp_rdy;
      out_x = m_valid && data_out_ready;
      if (out_x) m_total = (m_total + m_cnt > 2 ** SW - 1) ? 2 ** SW - 1 : m_total + m_cnt;
      if (in_x) begin
        mk = '0;
        c  = 0;
        for (int i = 0; i < P; i++) begin
          v     = $signed(data_in[i]);
          mk[i] = (v >= TH) || (v <= -TH);
          c     = c + int'(mk[i]);
        end
        m_data  = data_in;
        m_mask  = mk;
        m_cnt   = c;
        m_last  = (m_pos == RB - 1);
        m_row   = m_last && (m_any || (|mk));
        m_any   = m_last ? 1'b0 : (m_any || (|mk));
        m_pos   = m_last ? 0 : m_pos + 1;
        m_valid = 1;
      end else if (out_x) begin
        m_valid = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input beat_t d, input bit ordy);
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk4(input int a, input int b, input int c, input int e);
    beat_t r;
    r[0] = DW'(a);
    r[1] = DW'(b);
    r[2] = DW'(c);
    r[3] = DW'(e);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    int t;
    case ($urandom_range(0, 3))
      0: t = int'($urandom_range(0, 400)) - 200;
      1: case ($urandom_range(0, 5))
           0: t = 127;
           1: t = 128;
           2: t = -127;
           3: t = -128;
           4: t = -32768;
           default: t = 32767;
         endcase
      default: t = int'($urandom);
    endcase
    return DW'(t);
  endfunction

  function automatic beat_t rand_beat();
    beat_t r;
    for (int i = 0; i < P; i++) r[i] = rand_elem();
    return r;
  endfunction

  // Feed clean beats until the model sits at the start of a row.
  task automatic align_row();
    for (int k = 0; k < RB && m_pos != 0; k++) step(1, '0, 1);
    total++;
    if (m_pos != 0) begin
      bad++;
      $display("FAIL align_row: row position=%0d required=0", m_pos);
    end
  endtask

  beat_t beat_a, beat_b;

  initial begin
    // Reset state
    data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", data_out_valid, 0);
    check("reset_data", data_out, 0);
    check("reset_mask", outlier_mask, 0);
    check("reset_count", outlier_count, 0);
    check("reset_row", row_outlier, 0);
    check("reset_last", data_out_last, 0);
    check("reset_in_ready", data_in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Row aggregation
    step(1, mk4(0, 0, 0, 0), 1);
    check("row1_b1_last", data_out_last, 0);
    check("row1_b1_row", row_outlier, 0);
    step(1, mk4(0, 200, 0, 0), 1);
    check("row1_b2_last", data_out_last, 0);
    check("row1_b2_row", row_outlier, 0);
    check("row1_b2_mask", outlier_mask, 4'b0010);
    step(1, mk4(0, 0, 0, 0), 1);
    check("row1_b3_last", data_out_last, 1);
    check("row1_b3_row", row_outlier, 1);
    step(1, mk4(0, 0, 0, 0), 1);
    check("row2_b1_row", row_outlier, 0);
    step(1, mk4(0, 0, 0, 0), 1);
    step(1, mk4(0, 0, 0, 0), 1);
    check("row2_b3_last", data_out_last, 1);
    check("row2_b3_row", row_outlier, 0);

    // Threshold boundary and representable extremes
    step(1, mk4(127, 128, -127, -128), 1);
    check("bnd_mask", outlier_mask, 4'b1010);
    check("bnd_count", outlier_count, 2);
    check("bnd_data", data_out, mk4(127, 128, -127, -128));
    step(1, mk4(-32768, 32767, 0, -1), 1);
    check("ext_mask", outlier_mask, 4'b0011);
    check("ext_count", outlier_count, 2);
    step(0, '0, 1);
    check("drain_valid", data_out_valid, 0);

    // Backpressure: accept A, then hold B against a stalled output
    beat_a = mk4(1, -300, 2, 3);
    beat_b = mk4(400, 5, 6, -7);
    step(1, beat_a, 0);
    check("bp_accept_valid", data_out_valid, 1);
    check("bp_in_ready", data_in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, beat_b, 0);
      check("bp_hold_ready", data_in_ready, 0);
      check("bp_hold_data", data_out, beat_a);
      check("bp_hold_mask", outlier_mask, 4'b0010);
    end
    step(1, beat_b, 1);
    check("bp_release_data", data_out, beat_b);
    check("bp_release_mask", outlier_mask, 4'b0001);
    step(0, '0, 1);
    check("bp_drain_valid", data_out_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 9) < 7);
    end

    // Mid-row reset after beat 2 of a row holding an outlier
    align_row();
    step(1, mk4(0, 0, 500, 0), 1);
    step(1, mk4(0, 0, 0, 0), 1);
    rst = 1'b0;
    #1;
    check("mrst_valid", data_out_valid, 0);
    check("mrst_data", data_out, 0);
    check("mrst_mask", outlier_mask, 0);
    check("mrst_count", outlier_count, 0);
    check("mrst_row", row_outlier, 0);
    check("mrst_last", data_out_last, 0);
    check("mrst_in_ready", data_in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, mk4(0, 0, 0, 0), 1);
    check("mrst_b1_last", data_out_last, 0);
    step(1, mk4(0, 0, 0, 0), 1);
    check("mrst_b2_last", data_out_last, 0);
    step(1, mk4(0, 0, 0, 0), 1);
    check("mrst_b3_last", data_out_last, 1);
    check("mrst_b3_row", row_outlier, 0);
    step(0, '0, 1);

`ifdef OUTLIER_STATS_EN
    // Saturating statistics: 4 outliers per beat into a 4-bit counter
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, mk4(-200, 200, -32768, 32767), 1);
    step(1, mk4(-200, 200, -32768, 32767), 1);
    check("stats_1", total_outliers, 4);
    step(1, mk4(-200, 200, -32768, 32767), 1);
    check("stats_2", total_outliers, 8);
    step(1, mk4(-200, 200, -32768, 32767), 1);
    check("stats_3", total_outliers, 12);
    step(1, mk4(-200, 200, -32768, 32767), 1);
    check("stats_4", total_outliers, 15);
    step(0, '0, 1);
    check("stats_5", total_outliers, 15);
`endif

    step(0, '0, 1);
    step(0, '0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
